// File: rtl/coll_det_nd.sv
// rtl/coll_det_nd.sv - exact closest-approach collision predictor for two bodies in DIM axes
// Sequential MAC datapath: DIFF -> MAC (one axis per cycle) -> PROD -> CMP.
module coll_det_nd #(
  parameter int W   = 16,
  parameter int DIM = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_rdy,
  input  logic [DIM*W-1:0] p1,
  input  logic [DIM*W-1:0] v1,
  input  logic [DIM*W-1:0] p2,
  input  logic [DIM*W-1:0] v2,
  input  logic [W-1:0]     r2,
  output logic             busy,
  output logic             out_rdy,
  output logic             trial,
  output logic             overlap,
  output logic             approach
);

  localparam int DW = W + 1;
  localparam int SW = 2 * W + 2;
  localparam int KW = 2 * W + 3;
  localparam int CW = 4 * W + 6;
  localparam int HW = 3 * W + 2;

  generate
    if (DIM != 2 && DIM != 3) begin : g_bad_dim
      $error("coll_det_nd: DIM must be 2 or 3");
    end
  endgenerate

  typedef enum logic [2:0] {S_IDLE, S_DIFF, S_MAC, S_PROD, S_CMP} state_t;

  state_t                 state_q, state_d;
  logic [1:0]             cnt_q;
  logic [DIM*W-1:0]       p1_q, v1_q, p2_q, v2_q;
  logic [W-1:0]           r2_q;
  logic [DIM*DW-1:0]      d_q, u_q, diff_d, diff_u;
  logic [SW-1:0]          rsq_q, vsq_q;
  logic signed [KW-1:0]   k_q;
  logic signed [CW-1:0]   cross_q, cross_d;
  logic [HW-1:0]          rhs_q, rhs_d;
  logic                   out_rdy_q, trial_q, overlap_q, approach_q;

  logic signed [SW-1:0]   d_ext, u_ext, dd, uu, du;
  logic [CW-1:0]          rv;
  logic signed [CW-1:0]   k_ext, kk;
  logic                   ovl_c, appr_c, hit_c;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_rdy) state_d = S_DIFF;
      S_DIFF:  state_d = S_MAC;
      S_MAC:   if (cnt_q == 2'(DIM - 1)) state_d = S_PROD;
      S_PROD:  state_d = S_CMP;
      S_CMP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Sign-extend each operand by one bit so the difference can never wrap.
  always_comb begin
    diff_d = '0;
    diff_u = '0;
    for (int i = 0; i < DIM; i++) begin
      diff_d[i*DW +: DW] = {p1_q[i*W+W-1], p1_q[i*W +: W]} - {p2_q[i*W+W-1], p2_q[i*W +: W]};
      diff_u[i*DW +: DW] = {v1_q[i*W+W-1], v1_q[i*W +: W]} - {v2_q[i*W+W-1], v2_q[i*W +: W]};
    end
  end

  always_comb begin
    d_ext = {{(SW-DW){d_q[DW-1]}}, d_q[DW-1:0]};
    u_ext = {{(SW-DW){u_q[DW-1]}}, u_q[DW-1:0]};
    dd    = d_ext * d_ext;
    uu    = u_ext * u_ext;
    du    = d_ext * u_ext;
    rv    = {{(CW-SW){1'b0}}, rsq_q} * {{(CW-SW){1'b0}}, vsq_q};
    k_ext = {{(CW-KW){k_q[KW-1]}}, k_q};
    kk    = k_ext * k_ext;
    cross_d = $signed(rv) - kk;
    rhs_d   = {{(HW-SW){1'b0}}, vsq_q} * {{(HW-W){1'b0}}, r2_q};
    ovl_c   = rsq_q <= {{(SW-W){1'b0}}, r2_q};
    appr_c  = k_q[KW-1];
    hit_c   = $signed({{(CW-HW){1'b0}}, rhs_q}) >= cross_q;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      out_rdy_q  <= 1'b0;
      trial_q    <= 1'b0;
      overlap_q  <= 1'b0;
      approach_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_rdy_q <= (state_q == S_CMP);
      if (state_q == S_CMP) begin
        overlap_q  <= ovl_c;
        approach_q <= appr_c;
        trial_q    <= ovl_c | (appr_c & hit_c);
      end
    end
  end

  // Axis 0 always sits in the low slice; the operand vectors shift down each MAC cycle.
  always_ff @(posedge clock) begin
    case (state_q)
      S_IDLE: if (in_rdy) begin
        p1_q <= p1;
        v1_q <= v1;
        p2_q <= p2;
        v2_q <= v2;
        r2_q <= r2;
      end
      S_DIFF: begin
        d_q   <= diff_d;
        u_q   <= diff_u;
        rsq_q <= '0;
        vsq_q <= '0;
        k_q   <= '0;
        cnt_q <= '0;
      end
      S_MAC: begin
        rsq_q <= rsq_q + $unsigned(dd);
        vsq_q <= vsq_q + $unsigned(uu);
        k_q   <= k_q + $signed({du[SW-1], du});
        d_q   <= d_q >> DW;
        u_q   <= u_q >> DW;
        cnt_q <= cnt_q + 2'd1;
      end
      S_PROD: begin
        cross_q <= cross_d;
        rhs_q   <= rhs_d;
      end
      default: ;
    endcase
  end

  assign busy     = (state_q != S_IDLE);
  assign out_rdy  = out_rdy_q;
  assign trial    = trial_q;
  assign overlap  = overlap_q;
  assign approach = approach_q;

endmodule
